// File: rtl/fifo_enq_arbiter.sv
// Round-robin, packet-locked arbiter that shares one FIFO write port between
// N_REQ requesters and tags every enqueued word with its owner's ID.
module fifo_enq_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_enq,
  output logic [ID_W+WIDTH-1:0]  fifo_data,
  output logic                   grant_valid,
  output logic [ID_W-1:0]        grant_id,
  output logic [15:0]            stall_cnt
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] pick_id;
  logic            pick_any;
  logic [ID_W:0]   idx;
  logic            xfer;

  // Search order starts at rr_ptr and wraps at N_REQ; one spare bit holds rr_ptr+k.
  always_comb begin
    pick_id  = '0;
    pick_any = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_REQ))
        idx = idx - (ID_W+1)'(N_REQ);
      if (!pick_any && req_valid[idx[ID_W-1:0]]) begin
        pick_any = 1'b1;
        pick_id  = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rstn && state == LOCKED && !fifo_full)
      req_ready[grant_id] = 1'b1;
  end

  assign xfer      = !rstn && state == LOCKED && req_valid[grant_id] && !fifo_full;
  assign fifo_enq  = xfer;
  assign fifo_data = {grant_id, req_data[int'(grant_id)*WIDTH +: WIDTH]};

  always_ff @(posedge clk) begin
    if (rstn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      stall_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state       <= LOCKED;
            grant_valid <= 1'b1;
            grant_id    <= pick_id;
          end
        end
        LOCKED: begin
          if (xfer && req_last[grant_id]) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            rr_ptr      <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (state == LOCKED && req_valid[grant_id] && fifo_full && stall_cnt != '1)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: doc/fifo_enq_arbiter.md
Name: fifo_enq_arbiter

Overview:
- Shares one bus-side FIFO write port between N_REQ requesters using round-robin, packet-locked arbitration.
- A requester that wins keeps the FIFO until it sends its last beat, so bursts from different requesters never interleave in the FIFO.
- Each enqueued word is tagged with the owner's ID, so the dequeue side can demultiplex.
- Sits between the bus masters' write channels and the FIFO's data_in/enq/full interface.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 32, payload width per beat.
- ID_W, $clog2(N_REQ) (minimum 1), derived width of the ID tag; not overridden by the user.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-high: rstn=1 resets on the next rising clk edge.
- req_valid  in  N_REQ  per-requester beat valid.
- req_data  in  N_REQ*WIDTH  per-requester beat payload; requester i uses bits [i*WIDTH +: WIDTH].
- req_last  in  N_REQ  per-requester last-beat-of-burst flag; only meaningful while req_valid is high.
- req_ready  out  N_REQ  per-requester beat accept.
- fifo_full  in  1  full flag from the FIFO.
- fifo_enq  out  1  FIFO enqueue strobe.
- fifo_data  out  ID_W+WIDTH  tagged word, {owner_id, payload}.
- grant_valid  out  1  high while a requester owns the FIFO.
- grant_id  out  ID_W  current owner; holds the last owner when grant_valid=0.
- stall_cnt  out  16  saturating count of back-pressured cycles.

Behaviour:
- Reset (rstn=1 at a clock edge):
  - state=IDLE, rr_ptr=0, grant_valid=0, grant_id=0, stall_cnt=0.
  - While rstn=1: fifo_enq=0 and req_ready=0 (combinationally forced).
  - Reset mid-burst abandons the burst; the partial burst already in the FIFO is not retracted.
- States: IDLE, LOCKED.
- IDLE:
  - req_ready all 0, fifo_enq=0.
  - If any req_valid=1, the owner is the first index i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ... (wrapping at N_REQ, not at 2^ID_W).
  - Next cycle: state=LOCKED, grant_valid=1, grant_id=i.
  - Arbitration therefore costs exactly one cycle; the owner's first beat can be accepted in the cycle after its request is first seen in IDLE.
- LOCKED:
  - req_ready[grant_id]=!fifo_full; all other req_ready bits are 0.
  - Transfer occurs when req_valid[grant_id] && req_ready[grant_id]. Then fifo_enq=1 and fifo_data={grant_id, req_data[grant_id]}.
  - fifo_enq and fifo_data are combinational from the current inputs and grant register, with zero added latency.
  - Transfer with req_last[grant_id]=1: next state=IDLE, grant_valid=0, rr_ptr=(grant_id+1) mod N_REQ.
  - Owner deasserts req_valid mid-burst: the lock holds indefinitely. There is no timeout and no preemption.
  - fifo_full=1: no transfer, state holds; req_data must stay stable at the requester.
- stall_cnt:
  - +1 in each cycle where state=LOCKED, req_valid[grant_id]=1 and fifo_full=1.
  - Saturates at 16'hFFFF. Cleared only by reset.
- Non-owner requests:
  - They wait with req_ready=0; they must hold valid/data/last.
  - A non-owner dropping valid is legal and is simply not arbitrated.
- Single-beat burst: req_valid=1 with req_last=1 on the first beat gives a lock of one transfer, then return to IDLE.
- Back-to-back bursts have a minimum one-cycle IDLE bubble between them.
- fifo_enq is never asserted when fifo_full=1. The FIFO's own full guard is redundant but harmless.
- No combinational path from req_valid to req_ready. req_ready depends only on state, grant_id, fifo_full and rstn.

Test Plan:
- Reset then single request: hold rstn=1 for 2 cycles and check all outputs are 0. Then req_valid=4'b0100 with 3 beats A,B,C, last on C, fifo_full=0. Check grant_id=2 one cycle later, then fifo_enq on 3 consecutive cycles with fifo_data={2'd2,A},{2'd2,B},{2'd2,C}, then grant_valid=0.
- Round-robin fairness: all 4 requesters continuously send 1-beat bursts. Check the grant order is 0,1,2,3,0,1, with one IDLE cycle between grants.
- No interleaving: requester 1 is sending a 4-beat burst and requester 0 raises valid mid-burst. Check requester 0 gets req_ready=0 until requester 1's last beat, and the FIFO contains all 4 words tagged 1 before any tagged 0.
- Back-pressure: during a burst from requester 3, hold fifo_full=1 for 5 cycles. Check fifo_enq=0 and req_ready[3]=0 for those 5 cycles, stall_cnt increments from 0 to 5, and the burst resumes with no lost or duplicated beat.
- Owner gap and saturation: the owner deasserts valid for 3 cycles mid-burst. Check the lock holds and no other grant occurs. Separately, force 70000 stalled cycles and check stall_cnt=16'hFFFF.
- Reset mid-burst: assert rstn=1 on beat 2 of a 4-beat burst. Check no fifo_enq in the reset cycle, and state IDLE with rr_ptr=0 afterwards (the next contention 0 vs 2 grants 0).
